// File: rtl/mem_fill_responder_pkg.sv
// rtl/mem_fill_responder_pkg.sv - shared widths and response stage type for the fill responder
package mem_fill_responder_pkg;

  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 16;
  localparam int MAX_LATENCY = 8;
  localparam int INFLIGHT_W  = 4;

  // One slot of the read-return pipeline; a and d are don't-care when v=0.
  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } rsp_stage_t;

endpackage

// File: rtl/mem_fill_responder_if.sv
// rtl/mem_fill_responder_if.sv - request/response bus between cache fill logic and memory
interface mem_fill_responder_if;
  import mem_fill_responder_pkg::*;

  logic                  enable;
  logic                  wr;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     data_in;
  logic [DATA_W-1:0]     data_out;
  logic                  data_valid;
  logic [ADDR_W-1:0]     rsp_addr;
  logic [INFLIGHT_W-1:0] inflight;
  logic                  idle;

  // Cache side issues requests and consumes responses.
  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_valid, rsp_addr, inflight, idle
  );

  // Memory side accepts requests and returns read data.
  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_valid, rsp_addr, inflight, idle
  );

endinterface

// File: rtl/mem_fill_responder_word_store.sv
// rtl/mem_fill_responder_word_store.sv - single-port word array, clocked write, combinational read
module mem_fill_responder_word_store #(
  parameter int DEPTH_LOG2 = 15,
  parameter int DATA_W     = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  // Contents survive reset so a fill can resume from data stored before it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  // Read is combinational so a read issued the cycle after a write sees the new word.
  assign rdata = mem[idx];

endmodule

// File: rtl/mem_fill_responder.sv
// rtl/mem_fill_responder.sv - pipelined memory end of the cache block-fill protocol
module mem_fill_responder
  import mem_fill_responder_pkg::*;
#(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 15
) (
  input logic                 clk,
  input logic                 rst,
  mem_fill_responder_if.slave bus
);

  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("mem_fill_responder: LATENCY %0d outside 1..%0d", LATENCY, MAX_LATENCY);
  end

  logic                  rd_req;
  logic                  wr_req;
  logic [DATA_W-1:0]     rd_word;
  rsp_stage_t            issue;
  rsp_stage_t            stage [LATENCY];
  logic                  rsp_valid;
  logic [INFLIGHT_W-1:0] inflight_q;
  logic                  unused_addr_lsb;

  // Requests are ignored while reset is held, so writes are gated with rst too.
  assign rd_req          = bus.enable & ~bus.wr;
  assign wr_req          = rst & bus.enable & bus.wr;
  assign unused_addr_lsb = bus.addr[0];

  mem_fill_responder_word_store #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_store (
    .clk   (clk),
    .we    (wr_req),
    .idx   (bus.addr[DEPTH_LOG2:1]),
    .wdata (bus.data_in),
    .rdata (rd_word)
  );

  // Build the entry captured at the issue edge: word address with bit 0 cleared plus sampled data.
  always_comb begin
    issue   = '0;
    issue.v = rd_req;
    issue.a = {bus.addr[ADDR_W-1:1], 1'b0};
    issue.d = rd_word;
  end

  // Return pipeline: load at issue, shift every cycle; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= issue;
      for (int i = 1; i < LATENCY; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign rsp_valid = stage[LATENCY-1].v;

  // Outstanding reads, counting the one currently presented; issue and return together cancel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= '0;
    end else begin
      case ({rd_req, rsp_valid})
        2'b10:   inflight_q <= inflight_q + INFLIGHT_W'(1);
        2'b01:   inflight_q <= inflight_q - INFLIGHT_W'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  assign bus.data_valid = rsp_valid;
  assign bus.data_out   = stage[LATENCY-1].d;
  assign bus.rsp_addr   = stage[LATENCY-1].a;
  assign bus.inflight   = inflight_q;
  assign bus.idle       = (inflight_q == '0) & ~bus.enable;

endmodule

// File: tb/tb_mem_fill_responder.sv
// tb/tb_mem_fill_responder.sv - directed and random checks of mem_fill_responder against a reference model
module tb_mem_fill_responder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mem_fill_responder_if bus0 ();
  mem_fill_responder_if bus1 ();

  // Instance 0: default build. Instance 1: LATENCY=1 with a smaller store so bit 15 aliases.
  mem_fill_responder #(.LATENCY(4), .DEPTH_LOG2(15)) dut0 (.clk(clk), .rst(rst_n), .bus(bus0));
  mem_fill_responder #(.LATENCY(1), .DEPTH_LOG2(14)) dut1 (.clk(clk), .rst(rst_n), .bus(bus1));

  typedef struct {
    int          inst;
    int          due;
    logic [15:0] a;
    logic [15:0] d;
    bit          known;
  } exp_rsp_t;

  exp_rsp_t    pend[$];
  logic [15:0] mm [int];
  int          lat  [2] = '{4, 1};
  int          dlog [2] = '{15, 14};
  int          cyc;
  int          checks;
  int          errors;
  logic        cur_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // A read issued at edge n is presented after edge n+LATENCY-1, i.e. LATENCY cycles after it was driven.
  task automatic model_edge(input logic en, input logic wr, input logic [15:0] addr, input logic [15:0] data);
    for (int i = 0; i < 2; i++) begin
      int       key;
      exp_rsp_t e;
      key = i * 65536 + int'((32'(addr) >> 1) & ((1 << dlog[i]) - 1));
      if (rst_n === 1'b1 && en) begin
        if (wr) begin
          mm[key] = data;
        end else begin
          e.inst  = i;
          e.due   = cyc + lat[i] - 1;
          e.a     = addr & 16'hFFFE;
          e.known = mm.exists(key);
          e.d     = e.known ? mm[key] : 16'h0000;
          pend.push_back(e);
        end
      end
    end
  endtask

  task automatic check_inst(input int i, input logic dv, input logic [15:0] dout, input logic [15:0] radd,
                            input logic [3:0] infl, input logic idl, input string step_name);
    int n;
    int f;
    bit due_now;
    n = 0;
    f = -1;
    foreach (pend[k]) begin
      if (pend[k].inst == i) begin
        if (f < 0) f = k;
        n++;
      end
    end
    due_now = (f >= 0) && (pend[f].due == cyc);
    chk($sformatf("%s/i%0d/c%0d/data_valid", step_name, i, cyc), 32'(dv), 32'(due_now));
    chk($sformatf("%s/i%0d/c%0d/inflight", step_name, i, cyc), 32'(infl), 32'(n));
    chk($sformatf("%s/i%0d/c%0d/idle", step_name, i, cyc), 32'(idl), 32'(n == 0 && cur_en == 1'b0));
    if (due_now) begin
      chk($sformatf("%s/i%0d/c%0d/rsp_addr", step_name, i, cyc), 32'(radd), 32'(pend[f].a));
      if (pend[f].known) begin
        chk($sformatf("%s/i%0d/c%0d/data_out", step_name, i, cyc), 32'(dout), 32'(pend[f].d));
      end
    end
  endtask

  task automatic check_all(input string step_name);
    for (int k = pend.size() - 1; k >= 0; k--) begin
      if (pend[k].due < cyc) pend.delete(k);
    end
    check_inst(0, bus0.data_valid, bus0.data_out, bus0.rsp_addr, bus0.inflight, bus0.idle, step_name);
    check_inst(1, bus1.data_valid, bus1.data_out, bus1.rsp_addr, bus1.inflight, bus1.idle, step_name);
  endtask

  task automatic step(input logic en, input logic wr, input logic [15:0] addr, input logic [15:0] data,
                      input string step_name);
    bus0.enable = en;   bus1.enable = en;
    bus0.wr = wr;       bus1.wr = wr;
    bus0.addr = addr;   bus1.addr = addr;
    bus0.data_in = data; bus1.data_in = data;
    cur_en = en;
    @(posedge clk);
    cyc++;
    model_edge(en, wr, addr, data);
    @(negedge clk);
    check_all(step_name);
  endtask

  task automatic wr_op(input logic [15:0] addr, input logic [15:0] data, input string step_name);
    step(1'b1, 1'b1, addr, data, step_name);
  endtask

  task automatic rd_op(input logic [15:0] addr, input string step_name);
    step(1'b1, 1'b0, addr, 16'($urandom), step_name);
  endtask

  task automatic idle_op(input int n, input string step_name);
    for (int k = 0; k < n; k++) begin
      step(1'b0, 1'($urandom), 16'($urandom), 16'($urandom), step_name);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    cur_en = 1'b0;
    rst_n  = 1'b0;
    bus0.enable = 1'b0; bus0.wr = 1'b0; bus0.addr = '0; bus0.data_in = '0;
    bus1.enable = 1'b0; bus1.wr = 1'b0; bus1.addr = '0; bus1.data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    chk("reset/i0/data_valid", 32'(bus0.data_valid), 32'd0);
    chk("reset/i0/inflight",   32'(bus0.inflight),   32'd0);
    chk("reset/i0/idle",       32'(bus0.idle),       32'd1);
    chk("reset/i0/data_out",   32'(bus0.data_out),   32'd0);
    chk("reset/i0/rsp_addr",   32'(bus0.rsp_addr),   32'd0);
    chk("reset/i1/data_valid", 32'(bus1.data_valid), 32'd0);
    chk("reset/i1/inflight",   32'(bus1.inflight),   32'd0);
    chk("reset/i1/idle",       32'(bus1.idle),       32'd1);
    rst_n = 1'b1;

    wr_op(16'h0010, 16'hBEEF, "t1_wr");
    rd_op(16'h0010, "t1_rd");
    idle_op(6, "t1_drain");

    for (int k = 0; k < 8; k++) wr_op(16'(16'h0100 + 2 * k), 16'($urandom), "t2_prefill");
    for (int k = 0; k < 8; k++) rd_op(16'(16'h0100 + 2 * k), "t2_burst");
    idle_op(6, "t2_drain");

    wr_op(16'h0140, 16'($urandom), "t3_setup");
    rd_op(16'h0140, "t3_rd_old");
    wr_op(16'h0140, 16'h1234, "t3_wr");
    rd_op(16'h0140, "t3_rd_new");
    idle_op(6, "t3_drain");

    for (int k = 0; k < 8; k++) wr_op(16'(16'h0200 + 2 * k), 16'($urandom), "t4_prefill");
    for (int k = 0; k < 6; k++) rd_op(16'(16'h0200 + 2 * k), "t4_burst");
    rst_n = 1'b0;
    #1;
    pend.delete();
    check_all("t4_rst_async");
    rd_op(16'h020C, "t4_rd_in_rst");
    rd_op(16'h020E, "t4_rd_in_rst");
    idle_op(1, "t4_in_rst");
    rst_n = 1'b1;
    idle_op(6, "t4_after_rst");
    rd_op(16'h0200, "t4_reread");
    rd_op(16'h020E, "t4_reread");
    idle_op(6, "t4_drain");

    wr_op(16'h8020, 16'($urandom), "t5_setup");
    wr_op(16'h0021, 16'h5A5A, "t5_wr");
    rd_op(16'h0020, "t5_rd_lo");
    rd_op(16'h8020, "t5_rd_hi");
    idle_op(6, "t5_drain");

    for (int k = 0; k < 300; k++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
           16'(16'h0300 | ($urandom & 16'h003F) | ($urandom_range(0, 1) << 15)),
           16'($urandom), "rand");
    end
    idle_op(8, "rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
